// File: rtl/rgbw_fifo_serializer_pkg.sv
// -----------------------------------------------------------------------------
// rgbw_fifo_serializer_pkg
//
// Shared definitions for the SK6812RGBW FIFO serializer:
//   - serializer state encoding
//   - default pixel-word / FIFO geometry
//   - default one-wire bit timing, in clock cycles
//   - helper that sizes the timing down-counter
//
// No ports (package).
// -----------------------------------------------------------------------------
package rgbw_fifo_serializer_pkg;

    // Serializer FSM states.
    //   ST_IDLE  : line low, waiting for a word in the FIFO
    //   ST_FETCH : one-cycle FIFO read strobe
    //   ST_LOAD  : registered FIFO data is captured into the shift register
    //   ST_HIGH  : high phase of the current bit
    //   ST_LOW   : low phase of the current bit
    //   ST_LATCH : strip-reset low period after the FIFO has drained
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LOW   = 3'd4,
        ST_LATCH = 3'd5
    } ser_state_t;

    // Default geometry.
    localparam int DEF_DATA_SIZE   = 32;
    localparam int DEF_ADDR_SIZE   = 8;

    // Default bit timing in clock cycles.
    localparam int DEF_T0H         = 2;
    localparam int DEF_T0L         = 6;
    localparam int DEF_T1H         = 4;
    localparam int DEF_T1L         = 4;
    localparam int DEF_STR_RST     = 20;
    localparam int DEF_COUNTER_MAX = 7800;

    // Width of a down-counter able to hold every value 0..max_count.
    function automatic int counter_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rgbw_word_fifo.sv
// -----------------------------------------------------------------------------
// rgbw_word_fifo
//
// Single-clock FIFO for pixel words with a registered read port.
// Depth is 2^ADDR_SIZE. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate occupancy counter.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active low (clears pointers only)
//   w_data  in   word to enqueue
//   w_en    in   write strobe; ignored while full
//   r_en    in   read strobe; ignored while empty
//   r_data  out  read data, valid the cycle after an accepted read
//   w_full  out  FIFO full (derived from registered pointers)
//   r_empty out  FIFO empty (derived from registered pointers)
// -----------------------------------------------------------------------------
module rgbw_word_fifo
    import rgbw_fifo_serializer_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 w_en,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 w_full,
    output logic                 r_empty
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    // Storage has no reset so it maps onto block RAM.
    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE:0]   wr_ptr_reg;
    logic [ADDR_SIZE:0]   rd_ptr_reg;
    logic [DATA_SIZE-1:0] r_data_reg;

    logic wr_accept;
    logic rd_accept;

    // Equal pointers: empty. Same slot but opposite wrap bit: full.
    assign r_empty = (wr_ptr_reg == rd_ptr_reg);
    assign w_full  = (wr_ptr_reg[ADDR_SIZE] != rd_ptr_reg[ADDR_SIZE]) &&
                     (wr_ptr_reg[ADDR_SIZE-1:0] == rd_ptr_reg[ADDR_SIZE-1:0]);

    assign wr_accept = w_en && !w_full;
    assign rd_accept = r_en && !r_empty;

    assign r_data = r_data_reg;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[ADDR_SIZE-1:0]] <= w_data;
        end
    end

    // Registered read. A read and a write can only target the same slot when
    // the FIFO is empty (read rejected) or full (write rejected), so there is
    // no read-during-write hazard to resolve.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            r_data_reg <= mem[rd_ptr_reg[ADDR_SIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + (ADDR_SIZE + 1)'(1);
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + (ADDR_SIZE + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/rgbw_fifo_serializer.sv
// -----------------------------------------------------------------------------
// rgbw_fifo_serializer
//
// Buffers pixel words in a FIFO and drives them, MSB first, as the SK6812RGBW
// one-wire waveform. Each bit is a high phase followed by a low phase whose
// lengths depend on the bit value. Words already waiting in the FIFO follow
// each other directly (the last low phase stretches by the two fetch cycles);
// once the FIFO runs dry a strip-reset low period is appended before idling.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active low
//   w_data  in   pixel word to enqueue
//   w_en    in   write strobe
//   w_full  out  FIFO full
//   r_empty out  FIFO empty
//   out_sig out  registered serial LED data
// -----------------------------------------------------------------------------
module rgbw_fifo_serializer
    import rgbw_fifo_serializer_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int RGBW_T0H     = DEF_T0H,
    parameter int RGBW_T0L     = DEF_T0L,
    parameter int RGBW_T1H     = DEF_T1H,
    parameter int RGBW_T1L     = DEF_T1L,
    parameter int RGBW_STR_RST = DEF_STR_RST,
    parameter int COUNTER_MAX  = DEF_COUNTER_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 w_en,
    output logic                 w_full,
    output logic                 r_empty,
    output logic                 out_sig
);

    localparam int CNT_W = counter_width(COUNTER_MAX);
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(RGBW_T0H);
    localparam logic [CNT_W-1:0] T0L_C     = CNT_W'(RGBW_T0L);
    localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(RGBW_T1H);
    localparam logic [CNT_W-1:0] T1L_C     = CNT_W'(RGBW_T1L);
    localparam logic [CNT_W-1:0] STR_RST_C = CNT_W'(RGBW_STR_RST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    // FIFO interface.
    logic [DATA_SIZE-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Serializer state.
    ser_state_t           state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [DATA_SIZE-1:0] shift_data_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic                 out_sig_reg;
    logic                 rd_en_reg;

    // The counter is loaded with a phase length and the phase ends on the
    // cycle it reads 1, so a load of N yields exactly N cycles in that phase.
    logic cnt_done;
    logic cur_bit;
    logic next_bit;

    assign cnt_done = (cnt_reg == CNT_ONE);
    assign cur_bit  = shift_data_reg[DATA_SIZE-1];
    assign next_bit = shift_data_reg[DATA_SIZE-2];

    function automatic logic [CNT_W-1:0] high_time(input logic b);
        return b ? T1H_C : T0H_C;
    endfunction

    function automatic logic [CNT_W-1:0] low_time(input logic b);
        return b ? T1L_C : T0L_C;
    endfunction

    rgbw_word_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_en    (rd_en_reg),
        .r_data  (fifo_rd_data),
        .w_full  (fifo_full),
        .r_empty (fifo_empty)
    );

    assign w_full  = fifo_full;
    assign r_empty = fifo_empty;
    assign out_sig = out_sig_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            shift_data_reg <= '0;
            bit_idx_reg    <= '0;
            out_sig_reg    <= 1'b0;
            rd_en_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    out_sig_reg <= 1'b0;
                    if (!fifo_empty) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end

                // Read strobe is high for this single cycle; the FIFO
                // presents the word on its registered port next cycle.
                ST_FETCH: begin
                    rd_en_reg <= 1'b0;
                    state_reg <= ST_LOAD;
                end

                ST_LOAD: begin
                    shift_data_reg <= fifo_rd_data;
                    bit_idx_reg    <= IDX_LAST;
                    cnt_reg        <= high_time(fifo_rd_data[DATA_SIZE-1]);
                    out_sig_reg    <= 1'b1;
                    state_reg      <= ST_HIGH;
                end

                ST_HIGH: begin
                    if (cnt_done) begin
                        out_sig_reg <= 1'b0;
                        cnt_reg     <= low_time(cur_bit);
                        state_reg   <= ST_LOW;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (cnt_done) begin
                        if (bit_idx_reg != '0) begin
                            // Next bit goes straight to its high phase; the
                            // new MSB is the bit just below the current one.
                            shift_data_reg <= {shift_data_reg[DATA_SIZE-2:0], 1'b0};
                            bit_idx_reg    <= bit_idx_reg - IDX_ONE;
                            cnt_reg        <= high_time(next_bit);
                            out_sig_reg    <= 1'b1;
                            state_reg      <= ST_HIGH;
                        end else if (!fifo_empty) begin
                            // Back-to-back word: the line stays low through
                            // FETCH and LOAD, stretching this low by 2.
                            rd_en_reg <= 1'b1;
                            state_reg <= ST_FETCH;
                        end else begin
                            cnt_reg   <= STR_RST_C;
                            state_reg <= ST_LATCH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                // The strip-reset period always runs to completion; a word
                // written meanwhile is picked up from IDLE afterwards.
                ST_LATCH: begin
                    out_sig_reg <= 1'b0;
                    if (cnt_done) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                default: begin
                    out_sig_reg <= 1'b0;
                    rd_en_reg   <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_fifo_serializer.sv
// -----------------------------------------------------------------------------
// tb_rgbw_fifo_serializer
//
// Directed sequence with randomized pixel words. A monitor records the cycle
// of every rising and falling edge of out_sig; expected words, bit durations,
// gaps and latencies are derived from the waveform rules and compared with
// immediate assertions.
// -----------------------------------------------------------------------------
module tb_rgbw_fifo_serializer;

    localparam int T0H     = 2;
    localparam int T0L     = 6;
    localparam int T1H     = 4;
    localparam int T1L     = 4;
    localparam int STR_RST = 20;

    logic        clk;
    logic        rst;
    logic [31:0] w_data;
    logic        w_en;
    logic        w_full;
    logic        r_empty;
    logic        out_sig;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          rises[$];
    int          falls[$];
    logic [31:0] exp_words[$];

    rgbw_fifo_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .w_data  (w_data),
        .w_en    (w_en),
        .w_full  (w_full),
        .r_empty (r_empty),
        .out_sig (out_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge monitor: cyc counts rising clock edges; out_sig is sampled 1 time
    // unit after each edge, so a recorded value N means "changed at edge N".
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if ((out_sig === 1'b1) && !prev) begin
                rises.push_back(cyc);
            end else if ((out_sig !== 1'b1) && prev) begin
                falls.push_back(cyc);
            end
            prev = (out_sig === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int high_len(input logic b);
        return b ? T1H : T0H;
    endfunction

    function automatic int low_len(input logic b);
        return b ? T1L : T0L;
    endfunction

    // Caller is at a negedge; the write is taken at the next rising edge.
    task automatic write_word(input logic [31:0] d, output int wr_edge);
        w_data  = d;
        w_en    = 1'b1;
        wr_edge = cyc + 1;
        @(negedge clk);
        w_en    = 1'b0;
    endtask

    // Park at the negedge just before the given rising edge.
    task automatic wait_until_edge(input int target);
        while (cyc < target - 1) @(negedge clk);
    endtask

    task automatic wait_rises(input int target, input int limit);
        int budget;
        budget = limit;
        while ((rises.size() < target) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
    endtask

    // Decode the pulses starting at pulse index p0 against exp_words: every
    // high length must match the expected bit, lows are TxL inside a stream
    // and TxL+2 between consecutive words; decoded words must match in order.
    task automatic check_stream(input int p0, input string tag);
        int          n;
        int          budget;
        int          bad;
        int          i;
        int          hi;
        int          lo;
        int          exp_lo;
        logic        bv;
        logic [31:0] w;
        n      = exp_words.size();
        budget = 300 * n + 500;
        while ((falls.size() < p0 + 32 * n) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        check($sformatf("%s_complete", tag), (falls.size() >= p0 + 32 * n), 1'b1);
        if (falls.size() >= p0 + 32 * n) begin
            bad = 0;
            for (int k = 0; k < n; k++) begin
                w = '0;
                for (int b = 0; b < 32; b++) begin
                    i  = p0 + 32 * k + b;
                    bv = exp_words[k][31 - b];
                    hi = falls[i] - rises[i];
                    if (hi != high_len(bv)) bad++;
                    w = {w[30:0], (hi == T1H)};
                    if (i < p0 + 32 * n - 1) begin
                        lo     = rises[i + 1] - falls[i];
                        exp_lo = low_len(bv) + ((b == 31) ? 2 : 0);
                        if (lo != exp_lo) bad++;
                    end
                end
                check($sformatf("%s_word%0d", tag, k), w, exp_words[k]);
            end
            check($sformatf("%s_timing_errs", tag), bad, 0);
        end
    endtask

    initial begin
        int          we;
        int          p0;
        int          f;
        int          tl;
        int          n_before;
        logic [31:0] w;
        logic [31:0] prime;
        logic [31:0] batch[$];
        logic [31:0] four[4];

        four[0] = 32'h80102030;
        four[1] = 32'h80204060;
        four[2] = 32'h80306090;
        four[3] = 32'h804080C0;

        // ---------------- reset ----------------
        rst    = 1'b0;
        w_en   = 1'b0;
        w_data = '0;
        repeat (5) @(negedge clk);
        check("rst_out_sig", out_sig, 1'b0);
        check("rst_w_full",  w_full,  1'b0);
        check("rst_r_empty", r_empty, 1'b1);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_pulses", rises.size(), 0);
        check("idle_r_empty", r_empty, 1'b1);
        check("idle_out_sig", out_sig, 1'b0);

        // ---------------- single word ----------------
        p0 = rises.size();
        write_word(32'h80102030, we);
        check("single_r_empty", r_empty, 1'b0);
        wait_rises(p0 + 1, 20);
        check("single_latency", (rises.size() > p0) ? rises[p0] - we : -1, 3);
        exp_words = {32'h80102030};
        check_stream(p0, "single");
        check("single_b31_high", falls[p0] - rises[p0], T1H);
        check("single_b31_low", rises[p0 + 1] - falls[p0], T1L);
        check("single_b30_high", falls[p0 + 1] - rises[p0 + 1], T0H);
        check("single_b30_low", rises[p0 + 2] - falls[p0 + 1], T0L);
        check("single_span", falls[p0 + 31] - rises[p0], 256 - T0L);

        // Write on the very edge that ends the latch: picked up from IDLE.
        f  = falls[falls.size() - 1];
        tl = low_len(1'b0);
        wait_until_edge(f + tl + STR_RST);
        w  = $urandom;
        p0 = rises.size();
        write_word(w, we);
        wait_rises(p0 + 1, 40);
        check("latch_end_gap", (rises.size() > p0) ? rises[p0] - f : -1, tl + STR_RST + 3);
        exp_words = {w};
        check_stream(p0, "after_latch");

        // ---------------- write during latch ----------------
        f  = falls[falls.size() - 1];
        tl = low_len(w[0]);
        wait_until_edge(f + tl + 10);
        w  = $urandom;
        p0 = rises.size();
        write_word(w, we);
        check("latch_wr_r_empty", r_empty, 1'b0);
        wait_rises(p0 + 1, 60);
        check("latch_wr_start", (rises.size() > p0) ? rises[p0] - f : -1, tl + STR_RST + 3);
        exp_words = {w};
        check_stream(p0, "during_latch");

        // ---------------- four words, alternating cycles ----------------
        repeat (40) @(negedge clk);
        p0 = rises.size();
        exp_words.delete();
        for (int k = 0; k < 4; k++) begin
            write_word(four[k], we);
            @(negedge clk);
            exp_words.push_back(four[k]);
        end
        check_stream(p0, "four");
        repeat (60) @(negedge clk);
        check("four_pulse_count", rises.size() - p0, 128);

        // ---------------- random burst ----------------
        p0 = rises.size();
        exp_words.delete();
        for (int k = 0; k < 5; k++) begin
            w = $urandom;
            write_word(w, we);
            exp_words.push_back(w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check_stream(p0, "rand");
        repeat (40) @(negedge clk);

        // ---------------- fill ----------------
        // The prime word is taken out of the FIFO right away, keeping the
        // serializer busy for 256+ cycles while the next 257 writes arrive.
        p0    = rises.size();
        prime = $urandom;
        write_word(prime, we);
        for (int k = 1; k <= 257; k++) begin
            if (k == 256) check("fill_not_full_255", w_full, 1'b0);
            if (k == 257) check("fill_full_256", w_full, 1'b1);
            w = $urandom;
            batch.push_back(w);
            write_word(w, we);
        end
        check("fill_full_after_drop", w_full, 1'b1);
        exp_words.delete();
        exp_words.push_back(prime);
        for (int k = 0; k < 256; k++) exp_words.push_back(batch[k]);
        check_stream(p0, "fill");
        repeat (40) @(negedge clk);
        check("fill_word_count", (rises.size() - p0) / 32 - 1, 256);
        check("fill_drained", r_empty, 1'b1);

        // ---------------- reset mid-transmission ----------------
        p0 = rises.size();
        write_word($urandom, we);
        write_word($urandom, we);
        wait_rises(p0 + 12, 300);
        check("mid_in_bit20_high", out_sig, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_sig", out_sig, 1'b0);
        check("mid_rst_r_empty", r_empty, 1'b1);
        check("mid_rst_w_full", w_full, 1'b0);
        rst = 1'b1;
        n_before = rises.size();
        repeat (600) @(negedge clk);
        check("mid_rst_no_pulses", rises.size() - n_before, 0);
        check("mid_rst_idle_out", out_sig, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
